// File: rtl/dice_pkg.sv
// dice_pkg: shared state type, value width and seven-segment table
// for the multi-die roller.
package dice_pkg;

    localparam int VAL_W = 4;

    typedef enum logic [1:0] {IDLE, ROLL, RESULT, BUZZ} state_t;

    // Segments {A,B,C,D,E,F,G}, active high; entry 0 is the dash shown for illegal codes.
    localparam logic [9:0][6:0] SEG_TAB = {
        7'b1111011, 7'b1111111, 7'b1110000, 7'b1011111, 7'b1011011,
        7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000, 7'b0000001
    };

    function automatic logic [6:0] digit_to_seg(input logic [VAL_W-1:0] v);
        return (v >= VAL_W'(1) && v <= VAL_W'(9)) ? SEG_TAB[v] : SEG_TAB[0];
    endfunction

endpackage

// File: rtl/switch_debouncer.sv
// switch_debouncer: two-flop synchroniser followed by a stability counter;
// sw_db follows the synchronised switch only after DEBOUNCE steady clocks.
module switch_debouncer #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    output logic sw_db
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic          sw_meta_q, sw_s_q;
    logic          sw_db_q, sw_db_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sw_db_d = sw_db_q;
        cnt_d   = '0;
        if (sw_s_q != sw_db_q) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CW'(DEBOUNCE)) begin
                sw_db_d = sw_s_q;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_q <= 1'b0;
            sw_s_q    <= 1'b0;
            sw_db_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sw_meta_q <= sw;
            sw_s_q    <= sw_meta_q;
            sw_db_q   <= sw_db_d;
            cnt_q     <= cnt_d;
        end
    end

    assign sw_db = sw_db_q;

endmodule

// File: rtl/dice_roller_multi.sv
// dice_roller_multi: N_DICE independently prescaled dice driven by a debounced
// roll switch, with per-die hold, registered seven-segment decode and a match buzzer.
module dice_roller_multi
    import dice_pkg::*;
#(
    parameter int N_DICE      = 2,
    parameter int FACES       = 6,
    parameter int BASE_DIV    = 1,
    parameter int DEBOUNCE    = 4,
    parameter int BUZZ_CYCLES = 8
) (
    input  logic                    CLK,
    input  logic                    CLR_n,
    input  logic                    SW,
    input  logic [N_DICE-1:0]       HOLD,
    output logic [7*N_DICE-1:0]     SEG,
    output logic [VAL_W*N_DICE-1:0] VALUES,
    output logic                    ROLLING,
    output logic                    DONE,
    output logic                    MATCH,
    output logic                    Buzzer
);

    localparam int DIV_W  = $clog2(BASE_DIV + N_DICE);
    localparam int BUZZ_W = BUZZ_CYCLES > 1 ? $clog2(BUZZ_CYCLES) : 1;

    logic              sw_db, sw_prev_q, sw_rise, sw_fall, start, all_eq;
    state_t            state_q, state_d;
    logic              match_q, match_d;
    logic [BUZZ_W-1:0] buzz_q, buzz_d;

    switch_debouncer #(.DEBOUNCE(DEBOUNCE)) u_db (
        .clk  (CLK),
        .rst_n(CLR_n),
        .sw   (SW),
        .sw_db(sw_db)
    );

    always_comb begin
        sw_rise = sw_db & ~sw_prev_q;
        sw_fall = ~sw_db & sw_prev_q;
        start   = sw_rise && (state_q == IDLE || state_q == BUZZ);
        state_d = state_q;
        match_d = match_q;
        buzz_d  = '0;
        if (start) begin
            state_d = ROLL;
            match_d = 1'b0;
        end else if (state_q == ROLL && sw_fall) begin
            state_d = RESULT;
            match_d = all_eq;
        end else if (state_q == RESULT) begin
            state_d = (match_q && BUZZ_CYCLES > 0) ? BUZZ : IDLE;
        end else if (state_q == BUZZ) begin
            buzz_d  = buzz_q + 1'b1;
            state_d = (int'(buzz_q) >= BUZZ_CYCLES - 1) ? IDLE : BUZZ;
        end
    end

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            state_q   <= IDLE;
            match_q   <= 1'b0;
            buzz_q    <= '0;
            sw_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            match_q   <= match_d;
            buzz_q    <= buzz_d;
            sw_prev_q <= sw_db;
        end
    end

    // A single die can never "match"; held dice still take part in the comparison.
    always_comb begin
        all_eq = N_DICE > 1;
        for (int k = 1; k < N_DICE; k++)
            if (VALUES[VAL_W*k +: VAL_W] != VALUES[VAL_W-1:0]) all_eq = 1'b0;
    end

    for (genvar i = 0; i < N_DICE; i++) begin : g_die
        localparam int PER = BASE_DIV + i;
        logic [DIV_W-1:0] div_q, div_d;
        logic [VAL_W-1:0] val_q, val_d;
        logic [6:0]       seg_q, seg_d;
        logic             tc;
        // The edge that sees sw_db fall must not advance: the shown value is final.
        always_comb begin
            tc    = div_q == DIV_W'(PER - 1);
            div_d = start ? '0 : (state_q == ROLL ? (tc ? '0 : div_q + 1'b1) : div_q);
            val_d = (state_q == ROLL && tc && !HOLD[i] && !sw_fall)
                  ? (val_q == VAL_W'(FACES) ? VAL_W'(1) : val_q + 1'b1) : val_q;
            seg_d = digit_to_seg(val_q);
        end
        always_ff @(posedge CLK or negedge CLR_n) begin
            if (!CLR_n) begin
                div_q <= '0;
                val_q <= VAL_W'(1);
                seg_q <= digit_to_seg(VAL_W'(1));
            end else begin
                div_q <= div_d;
                val_q <= val_d;
                seg_q <= seg_d;
            end
        end
        assign VALUES[VAL_W*i +: VAL_W] = val_q;
        assign SEG[7*i +: 7]            = seg_q;
    end

    assign ROLLING = state_q == ROLL;
    assign DONE    = state_q == RESULT;
    assign MATCH   = match_q;
    assign Buzzer  = state_q == BUZZ && !sw_rise;

endmodule

// File: doc/dice_roller_multi.md
Name: dice_roller_multi

Overview:
- Parametrised successor to the two-digit dice design.
- N_DICE independent dice share one clock. Each die has its own prescaled advance rate, so the two-clock trick is no longer needed.
- The roll switch is synchronised and debounced. Individual dice can be locked with HOLD.
- Each die drives its own seven-segment digit. When a stopped roll shows all dice equal, the buzzer sounds for a programmable time.

Parameters:
- N_DICE, 2: number of dice/digits, range 1..8.
- FACES, 6: faces per die, range 2..9. Values run 1..FACES.
- BASE_DIV, 1: die i advances once every (BASE_DIV+i) clocks while rolling.
- DEBOUNCE, 4: consecutive stable synchronised samples required before the debounced switch changes, ≥1.
- BUZZ_CYCLES, 8: Buzzer high time in clocks on a match. 0 disables the buzzer.

Ports:
- CLK  in  1  system clock, rising edge.
- CLR_n  in  1  asynchronous active-low reset.
- SW  in  1  roll switch, asynchronous. High = roll, low = stop.
- HOLD  in  N_DICE  per-die lock, synchronous to CLK. 1 = die i frozen.
- SEG  out  7*N_DICE  die i on [7i+6:7i], ordered {A,B,C,D,E,F,G} MSB..LSB, active high.
- VALUES  out  4*N_DICE  die i binary value on [4i+3:4i].
- ROLLING  out  1  high while in state ROLL.
- DONE  out  1  one-cycle pulse when a roll stops.
- MATCH  out  1  registered on DONE: all dice equal. Held until the next roll starts.
- Buzzer  out  1  high while in state BUZZ.

Behaviour:
- Reset (CLR_n low, asynchronous):
  - All dice = 1, so every SEG digit = 0110000 and VALUES = 1 per die.
  - ROLLING, DONE, MATCH, Buzzer = 0. FSM = IDLE.
  - Sync, debounce and divider counters all cleared.
  - Mid-roll reset takes effect immediately. Release is synchronous to CLK.
- Switch path:
  - SW passes through a 2-flop synchroniser to sw_s.
  - sw_db copies sw_s after sw_s has differed from sw_db for DEBOUNCE consecutive clocks.
  - Any shorter glitch resets the stability count and is ignored.
- FSM states: IDLE, ROLL, RESULT, BUZZ.
  - IDLE → ROLL on sw_db rising. All divider counters reset to 0 on entry.
  - ROLL → RESULT on sw_db falling.
  - RESULT lasts 1 cycle: DONE=1 and MATCH is registered. Then → BUZZ if MATCH and BUZZ_CYCLES>0, else → IDLE.
  - BUZZ counts BUZZ_CYCLES clocks, then → IDLE.
  - sw_db rising during BUZZ → ROLL immediately. Buzzer drops on that cycle.
  - sw_db rising in IDLE or BUZZ clears MATCH.
- Dice in ROLL:
  - Divider i counts 0..BASE_DIV+i-1.
  - At terminal count, die i advances if HOLD[i]=0: value FACES wraps to 1, otherwise value+1.
  - Held dice keep their value while their dividers keep running.
  - Dice never change outside ROLL. The final value is the one present on the cycle sw_db falls.
- MATCH:
  - N_DICE=1 → always 0.
  - Otherwise all VALUES equal, held dice included.
- Decoding:
  - SEG is a registered decode of VALUES, 1 cycle behind.
  - Digit codes: 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - Any other code → 0000001 (dash). This is unreachable in legal operation.
- Latency: SW edge to ROLLING change = 2 (sync) + DEBOUNCE + 1 clocks, i.e. 7 at defaults.
- All HOLD set during a roll is legal: no die changes and DONE still pulses.

Decomposition:
- Package dice_pkg:
  - FSM state enum.
  - Seven-segment constant table.
  - Function digit_to_seg.
  - Width constant VAL_W=4.
- Sub-module switch_debouncer (parameter DEBOUNCE): contains the synchroniser and stability counter, outputs sw_db.
- Per-die counters are built with a generate loop in the top level.

Test Plan:
1. Reset: hold CLR_n low, then release → SEG = {0110000,0110000}, VALUES = {1,1}, Buzzer = 0, MATCH = 0.
2. SW high for 3 clocks only → ROLLING never asserts and dice stay 1. SW then held 30 clocks → ROLLING rises 7 clocks after the SW edge. Die0 steps 2,3,4,5,6,1,2… every clock; die1 steps every 2 clocks.
3. HOLD=2'b10, roll, release SW timed so die0 = 1 when sw_db falls → DONE pulses once, MATCH = 1, Buzzer high exactly 8 clocks, then IDLE.
4. Same as 3 but SW re-pressed during BUZZ → Buzzer falls the cycle sw_db rises, ROLLING = 1, MATCH cleared.
5. CLR_n pulsed low mid-roll (asynchronously, between clock edges) → all outputs return to reset values without a clock edge. After release, SW still high → a new roll starts after 7 clocks.
6. N_DICE=3, FACES=9, BASE_DIV=2: roll long enough → die2 advances every 4 clocks and wraps 9→1. Value 9 shows 1111011. Non-equal stop gives DONE with MATCH = 0 and Buzzer stays 0.
